mem_bus_arbiter: RTL

//   Shares one single-port memory bus (Wishbone-style, classic cycle) between IF (instruction fetch) and MEM (load/store).

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_arbiter_if.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port bus arbiter.
// State encodings and the stall-vector bit positions of the two consuming stages.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BUS_IF   = 3'd1,
        ST_BUS_MEM  = 3'd2,
        ST_HOLD_IF  = 3'd3,
        ST_HOLD_MEM = 3'd4,
        ST_DROP     = 3'd5
    } arb_state_e;

    localparam int STALL_IF  = 1;
    localparam int STALL_MEM = 4;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Wishbone-style classic-cycle bus between the arbiter (master) and memory (slave).
// cyc and stb are driven identically by the master.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  bus_cyc_o;
    logic                  bus_stb_o;
    logic                  bus_we_o;
    logic [DATA_W/8-1:0]   bus_sel_o;
    logic [ADDR_W-1:0]     bus_adr_o;
    logic [DATA_W-1:0]     bus_dat_o;
    logic [DATA_W-1:0]     bus_dat_i;
    logic                  bus_ack_i;

    modport master (
        output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o,
        input  bus_dat_i, bus_ack_i
    );

    modport slave (
        input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o,
        output bus_dat_i, bus_ack_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, stalling each
// stage until its access completes and holding returned data while it is frozen.
//
// state       | meaning
// ST_IDLE     | no bus cycle; MEM request has priority over IF
// ST_BUS_IF   | fetch cycle on the bus, waiting for ack
// ST_BUS_MEM  | load/store cycle on the bus, waiting for ack
// ST_HOLD_IF  | fetch done, IF still stalled; if_rdata held
// ST_HOLD_MEM | load done, MEM still stalled; mem_rdata held
// ST_DROP     | flushed cycle still running; data discarded at ack
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           stall,
    input  logic                 flush,
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic [DATA_W-1:0]    if_rdata,
    output logic                 stallreq_if,
    input  logic                 mem_req,
    input  logic                 mem_we,
    input  logic [DATA_W/8-1:0]  mem_sel,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_wdata,
    output logic [DATA_W-1:0]    mem_rdata,
    output logic                 stallreq_mem,
    mem_bus_arbiter_if.master    bus
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_e          state_q;
    logic                cyc_q;
    logic                we_q;
    logic [SEL_W-1:0]    sel_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   mem_rdata_q;
    logic                if_ack;
    logic                mem_ack;
    logic                unused_stall;

    assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!flush && mem_req) begin
                        cyc_q   <= 1'b1;
                        we_q    <= mem_we;
                        sel_q   <= mem_sel;
                        adr_q   <= mem_addr;
                        dat_q   <= mem_wdata;
                        state_q <= ST_BUS_MEM;
                    end else if (!flush && if_req) begin
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b0;
                        sel_q   <= '1;
                        adr_q   <= if_addr;
                        state_q <= ST_BUS_IF;
                    end
                end
                // An ack completes the access even if flush arrives in the same cycle.
                ST_BUS_IF: begin
                    if (bus.bus_ack_i) begin
                        if_rdata_q <= bus.bus_dat_i;
                        cyc_q      <= 1'b0;
                        we_q       <= 1'b0;
                        state_q    <= stall[STALL_IF] ? ST_HOLD_IF : ST_IDLE;
                    end else if (flush) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_BUS_MEM: begin
                    if (bus.bus_ack_i) begin
                        mem_rdata_q <= bus.bus_dat_i;
                        cyc_q       <= 1'b0;
                        we_q        <= 1'b0;
                        state_q     <= stall[STALL_MEM] ? ST_HOLD_MEM : ST_IDLE;
                    end else if (flush) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_HOLD_IF: begin
                    if (!stall[STALL_IF] || flush) state_q <= ST_IDLE;
                end
                ST_HOLD_MEM: begin
                    if (!stall[STALL_MEM] || flush) state_q <= ST_IDLE;
                end
                ST_DROP: begin
                    if (bus.bus_ack_i) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    cyc_q   <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack  = (state_q == ST_BUS_IF)  && bus.bus_ack_i;
    assign mem_ack = (state_q == ST_BUS_MEM) && bus.bus_ack_i;

    assign if_rdata     = if_ack  ? bus.bus_dat_i : if_rdata_q;
    assign mem_rdata    = mem_ack ? bus.bus_dat_i : mem_rdata_q;
    assign stallreq_if  = if_req  && !if_ack  && (state_q != ST_HOLD_IF);
    assign stallreq_mem = mem_req && !mem_ack && (state_q != ST_HOLD_MEM);

    assign bus.bus_cyc_o = cyc_q;
    assign bus.bus_stb_o = cyc_q;
    assign bus.bus_we_o  = we_q;
    assign bus.bus_sel_o = sel_q;
    assign bus.bus_adr_o = adr_q;
    assign bus.bus_dat_o = dat_q;

endmodule
